// File: rtl/qspa_pkg.sv
// Shared QSP pipeline types and sizing constants.
package qspa_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_REGS     = 16;
    localparam int REG_ADDR_W   = 4;
    localparam int MAX_INFLIGHT = 4;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } op_t;

endpackage

// File: rtl/qsp_scoreboard.sv
// Pending-write scoreboard and in-flight writer counter for the issue stage.
module qsp_scoreboard
    import qspa_pkg::*;
#(
    parameter int NUM_REGS     = qspa_pkg::NUM_REGS,
    parameter int MAX_INFLIGHT = qspa_pkg::MAX_INFLIGHT,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    output logic [NUM_REGS-1:0]   pend,
    output logic [CNT_W-1:0]      inflight
);

    logic [NUM_REGS-1:0] set_vec_s;
    logic [NUM_REGS-1:0] clr_vec_s;
    logic [CNT_W-1:0]    inflight_nxt_s;

    // Decode set/clear requests; a clear is applied first so a same-cycle set wins.
    always_comb begin
        set_vec_s      = {NUM_REGS{1'b0}};
        clr_vec_s      = {NUM_REGS{1'b0}};
        if (set_en) begin
            set_vec_s[set_addr] = 1'b1;
        end else begin
            set_vec_s = {NUM_REGS{1'b0}};
        end
        if (clr_en) begin
            clr_vec_s[clr_addr] = 1'b1;
        end else begin
            clr_vec_s[clr_addr] = 1'b0;
        end
        if (kill_en) begin
            clr_vec_s[kill_addr] = 1'b1;
        end else begin
            clr_vec_s[kill_addr] = clr_vec_s[kill_addr];
        end
        inflight_nxt_s = inflight + CNT_W'(set_en) - CNT_W'(clr_en) - CNT_W'(kill_en);
    end

    // Pending bits and in-flight count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= {NUM_REGS{1'b0}};
            inflight <= {CNT_W{1'b0}};
        end else begin
            pend     <= (pend & ~clr_vec_s) | set_vec_s;
            inflight <= inflight_nxt_s;
        end
    end

    qsp_scoreboard_chk #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .inflight (inflight)
    );

endmodule

// Range check on the in-flight counter; it must never exceed the configured limit.
module qsp_scoreboard_chk #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] inflight
);

    // Flag any out-of-range count outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(inflight) <= MAX_INFLIGHT);
        end
    end

endmodule

// File: rtl/qsp_issue_stage.sv
// QSP issue stage: hazard detection, writeback bypass/override and the execute slot.
module qsp_issue_stage
    import qspa_pkg::*;
#(
    parameter int DATA_WIDTH   = qspa_pkg::DATA_WIDTH,
    parameter int NUM_REGS     = qspa_pkg::NUM_REGS,
    parameter int MAX_INFLIGHT = qspa_pkg::MAX_INFLIGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  op_t                   iss_alu_op,
    input  logic [REG_ADDR_W-1:0] iss_rd_addr,
    input  logic                  iss_we,
    input  logic [DATA_WIDTH-1:0] iss_imm_ext,
    input  logic                  iss_use_imm,
    input  logic [REG_ADDR_W-1:0] iss_rs1_addr,
    input  logic [REG_ADDR_W-1:0] iss_rs2_addr,
    input  logic [DATA_WIDTH-1:0] iss_rs1_data,
    input  logic [DATA_WIDTH-1:0] iss_rs2_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ex_ready,
    output logic                  stall,
    output logic                  ex_valid,
    output op_t                   ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_we,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

    slot_t                 slot_r;
    logic [NUM_REGS-1:0]   pend_s;
    logic [NUM_REGS-1:0]   pend_eff_s;
    logic [CNT_W-1:0]      inflight_s;
    logic                  hazard_s, can_accept_s, issue_s, kill_s;
    logic                  wb_hit_a_s, wb_hit_b_s;
    logic [DATA_WIDTH-1:0] op_a_s, op_b_s, ovr_a_r, ovr_b_r;
    logic                  ovr_a_vld_r, ovr_b_vld_r;

    // Hazard, issue and stall decisions; a same-cycle writeback already counts as done.
    always_comb begin
        pend_eff_s = pend_s;
        if (wb_we) begin
            pend_eff_s[wb_rd_addr] = 1'b0;
        end else begin
            pend_eff_s = pend_s;
        end
        hazard_s     = pend_eff_s[iss_rs1_addr]
                     | (~iss_use_imm & pend_eff_s[iss_rs2_addr])
                     | (iss_we & pend_eff_s[iss_rd_addr])
                     | (inflight_s == CNT_W'(MAX_INFLIGHT));
        can_accept_s = (slot_r == SLOT_EMPTY) | ex_ready;
        issue_s      = (iss_alu_op != NOP) & ~hazard_s & can_accept_s & ~flush;
        stall        = (iss_alu_op != NOP) & ~issue_s;
        kill_s       = flush & ex_valid & ex_we;
    end

    // Operand select: live writeback, then captured override, then decode-time read.
    always_comb begin
        wb_hit_a_s = wb_we & (wb_rd_addr == iss_rs1_addr);
        wb_hit_b_s = wb_we & (wb_rd_addr == iss_rs2_addr);
        if (wb_hit_a_s) begin
            op_a_s = wb_data;
        end else if (ovr_a_vld_r) begin
            op_a_s = ovr_a_r;
        end else begin
            op_a_s = iss_rs1_data;
        end
        if (iss_use_imm) begin
            op_b_s = iss_imm_ext;
        end else if (wb_hit_b_s) begin
            op_b_s = wb_data;
        end else if (ovr_b_vld_r) begin
            op_b_s = ovr_b_r;
        end else begin
            op_b_s = iss_rs2_data;
        end
    end

    // Override capture for a held instruction; a fresh matching wb is kept even on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_a_vld_r <= 1'b0;
            ovr_b_vld_r <= 1'b0;
            ovr_a_r     <= {DATA_WIDTH{1'b0}};
            ovr_b_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            if (stall & wb_hit_a_s) begin
                ovr_a_vld_r <= 1'b1;
                ovr_a_r     <= wb_data;
            end else if (flush | ~stall) begin
                ovr_a_vld_r <= 1'b0;
            end
            if (stall & wb_hit_b_s) begin
                ovr_b_vld_r <= 1'b1;
                ovr_b_r     <= wb_data;
            end else if (flush | ~stall) begin
                ovr_b_vld_r <= 1'b0;
            end
        end
    end

    // Execute slot FSM with its registered payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r     <= SLOT_EMPTY;
            ex_alu_op  <= NOP;
            ex_rd_addr <= {REG_ADDR_W{1'b0}};
            ex_we      <= 1'b0;
            ex_op_a    <= {DATA_WIDTH{1'b0}};
            ex_op_b    <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            slot_r <= SLOT_EMPTY;
        end else if (issue_s) begin
            slot_r     <= SLOT_FULL;
            ex_alu_op  <= iss_alu_op;
            ex_rd_addr <= iss_rd_addr;
            ex_we      <= iss_we;
            ex_op_a    <= op_a_s;
            ex_op_b    <= op_b_s;
        end else if (ex_ready) begin
            slot_r <= SLOT_EMPTY;
        end
    end

    assign ex_valid = (slot_r == SLOT_FULL);

    qsp_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_s & iss_we),
        .set_addr  (iss_rd_addr),
        .clr_en    (wb_we),
        .clr_addr  (wb_rd_addr),
        .kill_en   (kill_s),
        .kill_addr (ex_rd_addr),
        .pend      (pend_s),
        .inflight  (inflight_s)
    );

endmodule

// File: tb/tb_qsp_issue_stage.sv
// Table-driven bench for qsp_issue_stage with hand-computed expectations.
module tb_qsp_issue_stage;
    import qspa_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    op_t         iss_alu_op;
    logic [3:0]  iss_rd_addr;
    logic        iss_we;
    logic [31:0] iss_imm_ext;
    logic        iss_use_imm;
    logic [3:0]  iss_rs1_addr;
    logic [3:0]  iss_rs2_addr;
    logic [31:0] iss_rs1_data;
    logic [31:0] iss_rs2_data;
    logic        wb_we;
    logic [3:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        stall;
    logic        ex_valid;
    op_t         ex_alu_op;
    logic [3:0]  ex_rd_addr;
    logic        ex_we;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        op_t         op;
        logic [3:0]  rd;
        logic        we;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        ui;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wbwe;
        logic [3:0]  wbrd;
        logic [31:0] wbd;
        logic        rdy;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic        e_we;
        logic [3:0]  e_rd;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    vec_t vecs[$];

    qsp_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_alu_op   (iss_alu_op),
        .iss_rd_addr  (iss_rd_addr),
        .iss_we       (iss_we),
        .iss_imm_ext  (iss_imm_ext),
        .iss_use_imm  (iss_use_imm),
        .iss_rs1_addr (iss_rs1_addr),
        .iss_rs2_addr (iss_rs2_addr),
        .iss_rs1_data (iss_rs1_data),
        .iss_rs2_data (iss_rs2_data),
        .wb_we        (wb_we),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .ex_ready     (ex_ready),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_alu_op    (ex_alu_op),
        .ex_rd_addr   (ex_rd_addr),
        .ex_we        (ex_we),
        .ex_op_a      (ex_op_a),
        .ex_op_b      (ex_op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input op_t op, input int rd, input int we, input int rs1,
                                input int rs2, input int ui, input logic [31:0] imm,
                                input logic [31:0] d1, input logic [31:0] d2, input int wbwe,
                                input int wbrd, input logic [31:0] wbd, input int rdy,
                                input int fl, input int es, input int ev, input int ewe,
                                input int erd, input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.op = op;       v.rd = 4'(rd);     v.we = (we != 0);
        v.rs1 = 4'(rs1); v.rs2 = 4'(rs2);   v.ui = (ui != 0);
        v.imm = imm;     v.d1 = d1;         v.d2 = d2;
        v.wbwe = (wbwe != 0); v.wbrd = 4'(wbrd); v.wbd = wbd;
        v.rdy = (rdy != 0);   v.fl = (fl != 0);
        v.e_stall = (es != 0); v.e_valid = (ev != 0); v.e_we = (ewe != 0);
        v.e_rd = 4'(erd); v.e_a = ea; v.e_b = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        iss_alu_op   = v.op;   iss_rd_addr  = v.rd;   iss_we       = v.we;
        iss_rs1_addr = v.rs1;  iss_rs2_addr = v.rs2;  iss_use_imm  = v.ui;
        iss_imm_ext  = v.imm;  iss_rs1_data = v.d1;   iss_rs2_data = v.d2;
        wb_we        = v.wbwe; wb_rd_addr   = v.wbrd; wb_data      = v.wbd;
        ex_ready     = v.rdy;  flush        = v.fl;
        #2;
        chk({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            chk({tag, ".ex_rd"}, 32'(ex_rd_addr), 32'(v.e_rd));
            chk({tag, ".ex_we"}, 32'(ex_we), 32'(v.e_we));
            chk({tag, ".op_a"}, ex_op_a, v.e_a);
            chk({tag, ".op_b"}, ex_op_b, v.e_b);
        end
    endtask

    initial begin
        // RAW stall resolved by same-cycle writeback bypass
        vecs.push_back(mk(OP_ADD, 3, 1, 1, 2, 0, 0, 32'h10, 32'h20, 0, 0, 0, 1, 0, 0, 1, 1, 3, 32'h10, 32'h20));
        vecs.push_back(mk(OP_ADD, 4, 1, 3, 2, 0, 0, 32'h11, 32'h22, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 4, 1, 3, 2, 0, 0, 32'h11, 32'h22, 1, 3, 32'h55, 1, 0, 0, 1, 1, 4, 32'h55, 32'h22));
        // Backpressure: slot holds while ex_ready is low
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(OP_ADD, 5, 1, 1, 2, 0, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, 1, 1, 1, 4, 32'h55, 32'h22));
        vecs.push_back(mk(OP_ADD, 5, 1, 1, 2, 0, 0, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0, 1, 1, 5, 32'h1, 32'h2));
        // Held reader captures wb r5 into the override register
        vecs.push_back(mk(OP_ADD, 6, 1, 5, 0, 0, 0, 32'h0F, 32'h3, 0, 0, 0, 0, 0, 1, 1, 1, 5, 32'h1, 32'h2));
        vecs.push_back(mk(OP_ADD, 6, 1, 5, 0, 0, 0, 32'h0F, 32'h3, 1, 5, 32'hAA, 0, 0, 1, 1, 1, 5, 32'h1, 32'h2));
        vecs.push_back(mk(OP_ADD, 6, 1, 5, 0, 0, 0, 32'h0F, 32'h3, 0, 0, 0, 0, 0, 1, 1, 1, 5, 32'h1, 32'h2));
        vecs.push_back(mk(OP_ADD, 6, 1, 5, 0, 0, 0, 32'h0F, 32'h3, 0, 0, 0, 1, 0, 0, 1, 1, 6, 32'hAA, 32'h3));
        // Drain r4, r6
        vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66, 1, 0, 0, 0, 0, 0, 0, 0));
        // Fill to MAX_INFLIGHT, fifth writer waits for a writeback
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(OP_ADD, i, 1, 0, 0, 0, 0, 32'(i), 0, 0, 0, 0, 1, 0, 0, 1, 1, i, 32'(i), 0));
        vecs.push_back(mk(OP_ADD, 5, 1, 0, 0, 0, 0, 32'h5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 5, 1, 0, 0, 0, 0, 32'h5, 0, 1, 1, 32'h77, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 5, 1, 0, 0, 0, 0, 32'h5, 0, 0, 0, 0, 1, 0, 0, 1, 1, 5, 32'h5, 0));
        for (int i = 2; i <= 5; i++)
            vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, i, 32'(i), 1, 0, 0, 0, 0, 0, 0, 0));
        // Flush kills a full slot writing r7; waiting r7 reader then issues
        vecs.push_back(mk(OP_ADD, 7, 1, 0, 0, 0, 0, 32'h7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 32'h7, 0));
        vecs.push_back(mk(OP_ADD, 8, 1, 7, 0, 0, 0, 32'h70, 32'h8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 8, 1, 7, 0, 0, 0, 32'h70, 32'h8, 0, 0, 0, 1, 0, 0, 1, 1, 8, 32'h70, 32'h8));
        // Immediate operand ignores pending rs2 (r8)
        vecs.push_back(mk(OP_ADD, 9, 1, 0, 8, 1, 32'h1234, 32'h9, 32'hBAD, 0, 0, 0, 1, 0, 0, 1, 1, 9, 32'h9, 32'h1234));
        // Set and clear of r8 in one cycle: set wins, so the r8 reader stalls
        vecs.push_back(mk(OP_ADD, 8, 1, 0, 0, 0, 0, 32'h1, 32'h2, 1, 8, 32'h88, 1, 0, 0, 1, 1, 8, 32'h1, 32'h2));
        vecs.push_back(mk(OP_ADD, 10, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 10, 1, 8, 0, 0, 0, 0, 0, 1, 8, 32'h99, 1, 0, 0, 1, 1, 10, 32'h99, 0));
        // Flush with an empty slot only blocks issue
        vecs.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 11, 0, 0, 0, 0, 0, 32'h3, 32'h4, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 11, 0, 0, 0, 0, 0, 32'h3, 32'h4, 0, 0, 0, 1, 0, 0, 1, 0, 11, 32'h3, 32'h4));

        rst = 1'b1; flush = 1'b0; iss_alu_op = NOP; iss_rd_addr = 4'd0; iss_we = 1'b0;
        iss_imm_ext = 32'd0; iss_use_imm = 1'b0; iss_rs1_addr = 4'd0; iss_rs2_addr = 4'd0;
        iss_rs1_data = 32'd0; iss_rs2_data = 32'd0; wb_we = 1'b0; wb_rd_addr = 4'd0;
        wb_data = 32'd0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ex_valid", 32'(ex_valid), 32'd0);
        chk("rst.ex_alu_op", 32'(ex_alu_op), 32'(NOP));
        chk("rst.ex_rd", 32'(ex_rd_addr), 32'd0);
        chk("rst.ex_we", 32'(ex_we), 32'd0);
        chk("rst.op_a", ex_op_a, 32'd0);
        chk("rst.op_b", ex_op_b, 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a stall, with flush and wb active, clears everything
        apply(mk(OP_ADD, 12, 1, 9, 0, 0, 0, 32'h5A, 0, 0, 0, 0, 0, 0, 1, 1, 0, 11, 32'h3, 32'h4), "mid.hold");
        rst = 1'b1;
        apply(mk(OP_ADD, 12, 1, 9, 0, 0, 0, 32'h5A, 0, 1, 9, 32'hEE, 0, 1, 1, 0, 0, 0, 0, 0), "mid.rst");
        chk("mid.ex_alu_op", 32'(ex_alu_op), 32'(NOP));
        chk("mid.ex_rd", 32'(ex_rd_addr), 32'd0);
        chk("mid.ex_we", 32'(ex_we), 32'd0);
        chk("mid.op_a", ex_op_a, 32'd0);
        chk("mid.op_b", ex_op_b, 32'd0);
        rst = 1'b0;
        apply(mk(OP_ADD, 12, 1, 9, 0, 0, 0, 32'h5A, 0, 0, 0, 0, 1, 0, 0, 1, 1, 12, 32'h5A, 0), "post.rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
